// File: rtl/syscall_string_printer.sv
// syscall_string_printer
//
// Consumes the syscall handler's print-string pulse. On print_req the block walks
// data memory from str_addr one word at a time and emits one byte per char
// handshake. It stops at the first NUL byte, which is never emitted, or after
// MAX_LEN characters. In the MAX_LEN case truncated is raised alongside done.
//
// Ports
//   clk         in   1   single clock, all logic on the rising edge
//   rst_n       in   1   synchronous, active-low reset
//   print_req   in   1   single-cycle request, only sampled while idle
//   str_addr    in   32  byte address of the first character (any alignment)
//   mem_rd_en   out  1   word read strobe
//   mem_addr    out  32  word-aligned read address
//   mem_rdata   in   32  read data, valid exactly one cycle after mem_rd_en
//   char_valid  out  1   char_data is valid
//   char_data   out  8   character byte
//   char_ready  in   1   consumer accepts the character when valid && ready
//   busy        out  1   high whenever a string is in flight
//   done        out  1   one-cycle pulse when a string finishes
//   truncated   out  1   qualifies done: string ended by MAX_LEN, not by NUL
module syscall_string_printer #(
    parameter int MAX_LEN    = 1024,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        print_req,
    input  logic [31:0] str_addr,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        busy,
    output logic        done,
    output logic        truncated
);

    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_ptr;
    logic [31:0]     r_buf;
    logic [CW-1:0]   r_count;
    logic            r_trunc;

    logic [7:0]      w_byte;
    logic            w_char_vld;
    logic            w_hs;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_last;

    // Byte lane selection for the current pointer offset within the buffered word.
    // Big-endian places offset 0 in the most significant byte (MIPS layout).
    function automatic logic [7:0] sel_lane(input logic [31:0] word, input logic [1:0] off);
        logic [1:0] lane;
        lane = BIG_ENDIAN ? (2'd3 - off) : off;
        case (lane)
            2'd0:    sel_lane = word[7:0];
            2'd1:    sel_lane = word[15:8];
            2'd2:    sel_lane = word[23:16];
            default: sel_lane = word[31:24];
        endcase
    endfunction

    always_comb begin
        w_byte     = sel_lane(r_buf, r_ptr[1:0]);
        // Valid comes only from state and buffered data, never from char_ready.
        w_char_vld = (r_state == S_EMIT) && (w_byte != 8'h00);
        w_hs       = w_char_vld && char_ready;
        w_cnt_inc  = r_count + CW'(1);
        w_last     = (w_cnt_inc == CW'(MAX_LEN));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (print_req) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_EMIT;
            S_EMIT: begin
                if (w_byte == 8'h00) begin
                    w_state_nxt = S_DONE;
                end else if (w_hs) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else if (r_ptr[1:0] == 2'd3) begin
                        // Crossing into the next word needs a fresh read.
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 32'h0;
            r_buf   <= 32'h0;
            r_count <= '0;
            r_trunc <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && print_req) begin
                r_ptr   <= str_addr;
                r_count <= '0;
                r_trunc <= 1'b0;
            end
            if (r_state == S_WAIT) begin
                r_buf <= mem_rdata;
            end
            if (w_hs) begin
                // The pointer wraps silently at the top of the address space.
                r_ptr   <= r_ptr + 32'd1;
                r_count <= w_cnt_inc;
                if (w_last) begin
                    r_trunc <= 1'b1;
                end
            end
        end
    end

    assign mem_rd_en  = (r_state == S_FETCH);
    assign mem_addr   = {r_ptr[31:2], 2'b00};
    assign char_valid = w_char_vld;
    assign char_data  = w_char_vld ? w_byte : 8'h00;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign truncated  = r_trunc;

endmodule
